// File: rtl/dma_io_fifo_device.sv
// ============================================================================
// Module   : dma_io_fifo_device
// Function : Device-to-CPU FIFO with a register port, a threshold interrupt
//            and DMA burst drain onto a shared tri-state data bus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_io_fifo_device #(
   parameter int DATA_W     = 32,
   parameter int DEPTH      = 32,
   parameter int IDX_W      = 9,
   parameter int THRESH_RST = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [IDX_W-1:0]   index,
   input  logic               IOWrite,
   input  logic               Ack,
   inout  wire  [DATA_W-1:0]  Data,
   input  logic               dev_valid,
   input  logic [DATA_W-1:0]  dev_data,
   output logic               dev_ready,
   output logic               GPIO1,
   output logic [$clog2(DEPTH):0] count
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int PTR_W = $clog2(DEPTH);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_BURST = 1'b1;

   localparam logic [1:0] A_STATUS = 2'd0;
   localparam logic [1:0] A_DATA   = 2'd1;
   localparam logic [1:0] A_THRESH = 2'd2;
   localparam logic [1:0] A_CTRL   = 2'd3;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic [CNT_W-1:0]  r_remaining;
   logic [CNT_W-1:0]  r_thresh;
   logic              r_irq_en;
   logic              r_underflow;
   logic              r_gpio;
   logic              r_oe;
   logic [DATA_W-1:0] r_odata;
   logic [0:0]        r_state;
   logic [0:0]        w_state_nxt;

   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;
   logic              w_cpu;
   logic              w_rd;
   logic              w_wr;
   logic [1:0]        w_addr;
   logic              w_cpu_pop;
   logic              w_flush;
   logic              w_grant;
   logic              w_bpop;
   logic              w_busy;
   logic [DATA_W-1:0] w_status;
   logic [DATA_W-1:0] w_rdata;

   assign w_full    = (r_count == CNT_W'(DEPTH));
   assign w_empty   = (r_count == '0);
   assign w_addr    = index[1:0];
   // Ack owns the bus: a DMA grant masks any concurrent CPU select.
   assign w_cpu     = index[IDX_W-1] && !Ack;
   assign w_rd      = w_cpu && !IOWrite;
   assign w_wr      = w_cpu && IOWrite;
   assign w_cpu_pop = w_rd && (w_addr == A_DATA) && !w_empty;
   assign w_flush   = w_wr && (w_addr == A_CTRL) && Data[0];
   assign w_push    = dev_valid && !w_full;
   assign w_pop     = w_cpu_pop || w_grant || w_bpop;

   assign dev_ready = !w_full;
   assign GPIO1     = r_gpio;
   assign count     = r_count;
   assign Data      = r_oe ? r_odata : 'z;

   wire w_unused = &{1'b0, index[IDX_W-2:2], Data};

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM: next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_grant && (r_count != CNT_W'(1))) begin
               w_state_nxt = S_BURST;
            end
         end
         S_BURST: begin
            if (w_flush) begin
               w_state_nxt = S_IDLE;
            end else if (Ack && (w_empty || (r_remaining == CNT_W'(1)))) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // FSM: outputs (the grant cycle already moves the first word)
   always_comb begin
      w_grant = 1'b0;
      w_bpop  = 1'b0;
      w_busy  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_grant = Ack && !IOWrite && !w_empty;
         end
         S_BURST: begin
            w_bpop = Ack && !w_empty;
            w_busy = 1'b1;
         end
         default: begin
            w_busy = 1'b0;
         end
      endcase
   end

   always_comb begin
      w_status                = '0;
      w_status[CNT_W-1:0]     = r_count;
      w_status[16]            = w_empty;
      w_status[17]            = w_full;
      w_status[18]            = r_gpio;
      w_status[19]            = r_underflow;
      w_status[20]            = w_busy;
   end

   always_comb begin
      w_rdata = '0;
      case (w_addr)
         A_STATUS: w_rdata = w_status;
         A_DATA:   w_rdata = w_empty ? '0 : r_mem[r_rd_ptr];
         A_THRESH: w_rdata[CNT_W-1:0] = r_thresh;
         A_CTRL:   w_rdata = '0;
         default:  w_rdata = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_push && !w_flush) begin
         r_mem[r_wr_ptr] <= dev_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_remaining <= '0;
         r_thresh    <= CNT_W'(THRESH_RST);
         r_irq_en    <= 1'b1;
         r_underflow <= 1'b0;
         r_gpio      <= 1'b0;
         r_oe        <= 1'b0;
         r_odata     <= '0;
      end else begin
         if (w_flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_remaining <= '0;
         end else begin
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + CNT_W'(1);
               2'b01:   r_count <= r_count - CNT_W'(1);
               default: r_count <= r_count;
            endcase
            if (w_grant) begin
               r_remaining <= r_count - CNT_W'(1);
            end else if (w_bpop) begin
               r_remaining <= r_remaining - CNT_W'(1);
            end
         end

         if (w_grant || w_bpop) begin
            r_odata <= r_mem[r_rd_ptr];
            r_oe    <= 1'b1;
         end else if (w_rd) begin
            r_odata <= w_rdata;
            r_oe    <= 1'b1;
         end else begin
            r_oe    <= 1'b0;
         end

         if (w_rd && (w_addr == A_STATUS)) begin
            r_underflow <= 1'b0;
         end else if (w_rd && (w_addr == A_DATA) && w_empty) begin
            r_underflow <= 1'b1;
         end

         if (w_wr && (w_addr == A_THRESH)) begin
            r_thresh <= Data[CNT_W-1:0];
         end
         if (w_wr && (w_addr == A_CTRL)) begin
            r_irq_en <= Data[1];
         end

         // Request line is held low across a burst and re-armed once idle.
         if ((r_state == S_IDLE) && !w_grant) begin
            r_gpio <= r_irq_en && (r_count >= r_thresh) && !w_empty;
         end else begin
            r_gpio <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dma_io_fifo_device.sv
// ============================================================================
// Module   : tb_dma_io_fifo_device
// Function : Directed self-checking bench for dma_io_fifo_device.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dma_io_fifo_device;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 32;
   localparam int IDX_W  = 9;
   localparam int CNT_W  = 6;

   logic              clk = 1'b0;
   logic              rst;
   logic [IDX_W-1:0]  index;
   logic              IOWrite;
   logic              Ack;
   wire  [DATA_W-1:0] Data;
   logic              dev_valid;
   logic [DATA_W-1:0] dev_data;
   logic              dev_ready;
   logic              GPIO1;
   logic [CNT_W-1:0]  count;

   logic              r_tb_drv;
   logic [DATA_W-1:0] r_tb_d;
   logic [DATA_W-1:0] rd;
   int                n_pass = 0;
   int                n_chk  = 0;

   assign Data = r_tb_drv ? r_tb_d : 'z;

   always #5 clk = ~clk;

   dma_io_fifo_device #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W), .THRESH_RST(1)
   ) dut (
      .clk(clk), .rst(rst), .index(index), .IOWrite(IOWrite), .Ack(Ack),
      .Data(Data), .dev_valid(dev_valid), .dev_data(dev_data),
      .dev_ready(dev_ready), .GPIO1(GPIO1), .count(count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_rd(input logic [1:0] a, output logic [31:0] d);
      index   = {1'b1, 6'b0, a};
      IOWrite = 1'b0;
      Ack     = 1'b0;
      tick();
      d     = Data;
      index = '0;
   endtask

   task automatic cpu_wr(input logic [1:0] a, input logic [31:0] v);
      index    = {1'b1, 6'b0, a};
      IOWrite  = 1'b1;
      r_tb_d   = v;
      r_tb_drv = 1'b1;
      tick();
      index    = '0;
      IOWrite  = 1'b0;
      r_tb_drv = 1'b0;
   endtask

   task automatic push(input logic [31:0] v);
      dev_valid = 1'b1;
      dev_data  = v;
      tick();
      dev_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; index = '0; IOWrite = 1'b0; Ack = 1'b0;
      dev_valid = 1'b0; dev_data = '0; r_tb_drv = 1'b0; r_tb_d = '0;
      tick(); tick();
      rst = 1'b0;
      check("rst_count", 32'(count), 32'd0);
      check("rst_ready", 32'(dev_ready), 32'd1);
      check("rst_gpio", 32'(GPIO1), 32'd0);
      check("rst_oe", 32'(dut.r_oe), 32'd0);

      // Three words, threshold 1: request asserted
      push(32'hA000_000A); push(32'hB000_000B); push(32'hC000_000C);
      tick();
      check("abc_count", 32'(count), 32'd3);
      check("abc_gpio", 32'(GPIO1), 32'd1);
      cpu_rd(2'd0, rd);
      check("abc_status", rd, 32'h0004_0003);

      // Three-cycle DMA burst
      Ack = 1'b1;
      tick(); check("burst_A", Data, 32'hA000_000A);
      tick(); check("burst_B", Data, 32'hB000_000B);
      check("burst_gpio", 32'(GPIO1), 32'd0);
      tick(); check("burst_C", Data, 32'hC000_000C);
      Ack = 1'b0;
      check("burst_count", 32'(count), 32'd0);
      tick();
      check("burst_oe_off", 32'(dut.r_oe), 32'd0);
      check("burst_gpio_after", 32'(GPIO1), 32'd0);
      cpu_rd(2'd0, rd);
      check("burst_status_idle", rd, 32'h0001_0000);

      // Four-word burst with a two-cycle pause after word 2
      push(32'h1111_1111); push(32'h2222_2222); push(32'h3333_3333); push(32'h4444_4444);
      tick();
      Ack = 1'b1;
      tick(); check("gap_w1", Data, 32'h1111_1111);
      tick(); check("gap_w2", Data, 32'h2222_2222);
      Ack = 1'b0;
      cpu_rd(2'd0, rd);
      check("gap_status", rd, 32'h0010_0002);
      tick();
      check("gap_oe_off", 32'(dut.r_oe), 32'd0);
      check("gap_count", 32'(count), 32'd2);
      Ack = 1'b1;
      tick(); check("gap_w3", Data, 32'h3333_3333);
      tick(); check("gap_w4", Data, 32'h4444_4444);
      Ack = 1'b0;
      check("gap_count_end", 32'(count), 32'd0);
      tick();
      check("gap_idle", 32'(dut.r_state), 32'd0);

      // Fill to DEPTH across the pointer wrap, then drain by CPU
      for (int i = 0; i < DEPTH; i++) push(32'h100 + 32'(i));
      check("full_count", 32'(count), 32'd32);
      check("full_ready", 32'(dev_ready), 32'd0);
      push(32'hDEAD_BEEF);
      check("full_ignore", 32'(count), 32'd32);
      cpu_rd(2'd0, rd);
      check("full_status", rd, 32'h0006_0020);
      for (int i = 0; i < DEPTH; i++) begin
         cpu_rd(2'd1, rd);
         check($sformatf("drain_%0d", i), rd, 32'h100 + 32'(i));
      end
      check("drain_count", 32'(count), 32'd0);

      // Underflow is sticky until a STATUS read
      cpu_rd(2'd1, rd);
      check("uf_data", rd, 32'd0);
      cpu_rd(2'd0, rd);
      check("uf_status1", rd, 32'h0009_0000);
      cpu_rd(2'd0, rd);
      check("uf_status2", rd, 32'h0001_0000);

      // Threshold 4, irq enable, flush mid-burst
      cpu_wr(2'd2, 32'd4);
      cpu_rd(2'd2, rd);
      check("thresh_rd", rd, 32'd4);
      push(32'h5); push(32'h6); push(32'h7);
      tick();
      check("th_gpio3", 32'(GPIO1), 32'd0);
      push(32'h8);
      tick();
      check("th_gpio4", 32'(GPIO1), 32'd1);
      cpu_wr(2'd3, 32'h0);
      tick();
      check("irq_off", 32'(GPIO1), 32'd0);
      cpu_wr(2'd3, 32'h2);
      Ack = 1'b1;
      tick(); check("fl_w1", Data, 32'h5);
      Ack = 1'b0;
      check("fl_busy", 32'(dut.r_state), 32'd1);
      cpu_wr(2'd3, 32'h3);
      check("fl_count", 32'(count), 32'd0);
      check("fl_idle", 32'(dut.r_state), 32'd0);
      check("fl_oe", 32'(dut.r_oe), 32'd0);

      // Ack with IOWrite = 1 in IDLE is not a grant
      push(32'h55);
      Ack = 1'b1; IOWrite = 1'b1;
      tick();
      Ack = 1'b0; IOWrite = 1'b0;
      cpu_rd(2'd0, rd);
      check("ackwr_status", rd, 32'h0000_0001);

      // Reset wins over a concurrent push
      dev_valid = 1'b1; dev_data = 32'h77; rst = 1'b1;
      tick();
      rst = 1'b0; dev_valid = 1'b0;
      check("rst2_count", 32'(count), 32'd0);
      check("rst2_ready", 32'(dev_ready), 32'd1);
      cpu_rd(2'd2, rd);
      check("rst2_thresh", rd, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/dma_io_fifo_device.md
DMA_IO_FIFO_DEVICE -- requirements
Module: dma_io_fifo_device

Interface
REQ-001 Parameter DATA_W, default 32: word width of Data and buffer entries; SHALL be >= 21.
REQ-002 Parameter DEPTH, default 32: buffer entries; SHALL be a power of two, >= 2.
REQ-003 Parameter IDX_W, default 9: index width; index[IDX_W-1] is chip select, index[1:0] is register address.
REQ-004 Parameter THRESH_RST, default 1: reset value of the interrupt threshold register.
REQ-005 Localparam CNT_W = $clog2(DEPTH)+1.
REQ-006 clk  in  1  sole clock; all state updates on posedge clk.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 index  in  IDX_W  CPU register select.
REQ-009 IOWrite  in  1  1 = CPU write, 0 = read.
REQ-010 Ack  in  1  DMA acknowledge; 1 grants/continues a burst.
REQ-011 Data  inout  DATA_W  shared bus; driven only while data_oe = 1, else high-Z.
REQ-012 dev_valid  in  1  device side offers dev_data.
REQ-013 dev_data  in  DATA_W  device word.
REQ-014 dev_ready  out  1  = !full; push occurs when dev_valid && dev_ready.
REQ-015 GPIO1  out  1  interrupt/DMA request.
REQ-016 count  out  CNT_W  current occupancy, 0..DEPTH.

Function
REQ-017 Buffer SHALL be a circular FIFO (wr_ptr, rd_ptr wrap modulo DEPTH); push and pop in one cycle leave count unchanged.
REQ-018 Push while full SHALL NOT occur (dev_ready = 0), even if a pop happens that cycle.
REQ-019 CPU access SHALL occur when index[IDX_W-1] = 1 and Ack = 0; Ack = 1 overrides CS (CPU access ignored).
REQ-020 Register map: addr 0 STATUS (R); 1 DATA (R, pops head); 2 THRESH (R/W, low CNT_W bits); 3 CTRL (W: bit0 flush, bit1 irq_en).
REQ-021 STATUS = {.., busy bit20, underflow bit19, GPIO1 bit18, full bit17, empty bit16, zero-pad, count[CNT_W-1:0]}; unused bits 0.
REQ-022 Reads SHALL have 1-cycle latency: access sampled at edge N, Data driven with registered odata, data_oe = 1, during cycle N..N+1; data_oe = 0 otherwise.
REQ-023 DATA read when empty SHALL return 0, not pop, set sticky underflow; STATUS read SHALL clear underflow after returning it.
REQ-024 Writes to STATUS/DATA SHALL be ignored; flush SHALL zero pointers and count in one cycle.
REQ-025 FSM states IDLE, BURST.
REQ-026 IDLE: GPIO1 = irq_en && (count >= thresh) && (count != 0), registered.
REQ-027 IDLE -> BURST when Ack = 1, IOWrite = 0, count != 0; latch remaining = count; GPIO1 <= 0.
REQ-028 Ack = 1 with IOWrite = 1, or with count = 0, in IDLE SHALL be ignored.
REQ-029 BURST: each cycle Ack = 1 SHALL pop one word onto Data (latency per REQ-022), remaining - 1; Ack = 0 pauses (no pop, Data high-Z).
REQ-030 BURST -> IDLE on the pop that makes remaining 0; words pushed during a burst are not included.
REQ-031 GPIO1 SHALL stay 0 in BURST; re-evaluated per REQ-026 from the first IDLE cycle.
REQ-032 Flush during BURST SHALL abort to IDLE with data_oe = 0 next cycle.

Reset
REQ-033 On rst: pointers, count, remaining = 0; state IDLE; thresh = THRESH_RST; irq_en = 1; underflow = 0; GPIO1 = 0; data_oe = 0 (Data high-Z); odata = 0.
REQ-034 rst SHALL override every concurrent push, pop, CPU access or burst; dev_ready = 1 the cycle after.

Verification
REQ-035 Reset, push 3 words (A,B,C), THRESH 1 -> GPIO1 = 1, count = 3, STATUS = 0x00040003.
REQ-036 Ack = 1 for 3 cycles, IOWrite = 0 -> Data = A,B,C on consecutive cycles, GPIO1 = 0, count = 0, state IDLE, Data high-Z after.
REQ-037 Burst of 4 with Ack dropped 2 cycles after word 2 -> no pop during gap, words 3-4 resume, order preserved.
REQ-038 DEPTH pushes -> full, dev_ready = 0; further dev_valid ignored; DEPTH DATA reads return words in order across pointer wrap.
REQ-039 DATA read when empty -> Data = 0, STATUS bit19 = 1; second STATUS read -> bit19 = 0.
REQ-040 THRESH = 4, 3 pushes -> GPIO1 = 0; 4th push -> GPIO1 = 1; CTRL irq_en = 0 -> GPIO1 = 0; flush mid-burst -> count 0, IDLE.
